// File: rtl/trace_capture.sv
// Observation-side trace capture: samples DUT output nets every clock and streams
// timestamped {ts, sample} records out of a show-ahead FIFO over valid/ready.
module trace_capture #(
    parameter int SIG_W = 8,
    parameter int TS_W  = 16,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   arm,
    input  logic                   stop,
    input  logic                   on_change,
    input  logic [SIG_W-1:0]       sig_in,
    output logic                   rec_valid,
    input  logic                   rec_ready,
    output logic [TS_W+SIG_W-1:0]  rec_data,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] CAPTURE = 2'd1;
    localparam logic [1:0] DRAIN   = 2'd2;

    logic [1:0]            state;
    logic [TS_W-1:0]       ts;
    logic [SIG_W-1:0]      prev;
    logic                  firstCycle;
    logic                  doneReg;
    logic                  overflowReg;

    logic [AW:0]           wrPtr;
    logic [AW:0]           rdPtr;
    logic [TS_W+SIG_W-1:0] mem [DEPTH];

    logic empty;
    logic full;
    logic pop;
    logic wantPush;
    logic push;

    // The extra pointer bit tells a full FIFO apart from an empty one.
    assign empty = (wrPtr == rdPtr);
    assign full  = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign pop   = !empty && rec_ready;

    assign wantPush = (state == CAPTURE) &&
                      (firstCycle || !on_change || (sig_in != prev) || (ts == '1));
    assign push     = wantPush && (!full || pop);

    assign rec_valid = !empty;
    assign rec_data  = empty ? '0 : mem[rdPtr[AW-1:0]];
    assign busy      = (state != IDLE);
    assign done      = doneReg;
    assign overflow  = overflowReg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ts          <= '0;
            prev        <= '0;
            firstCycle  <= 1'b0;
            doneReg     <= 1'b0;
            overflowReg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // A stop arriving with arm is simply dropped here.
                    if (arm) begin
                        state       <= CAPTURE;
                        ts          <= '0;
                        firstCycle  <= 1'b1;
                        doneReg     <= 1'b0;
                        overflowReg <= 1'b0;
                    end
                end
                CAPTURE: begin
                    ts         <= ts + 1'b1;
                    prev       <= sig_in;
                    firstCycle <= 1'b0;
                    if (wantPush && !push) begin
                        overflowReg <= 1'b1;
                    end
                    if (stop) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (empty) begin
                        state   <= IDLE;
                        doneReg <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end
        end
    end

    // Storage needs no reset: the read side is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr[AW-1:0]] <= {ts, sig_in};
        end
    end

endmodule

// File: tb/tb_trace_capture.sv
// Bench for trace_capture: directed vector table, corner-case sequences and
// randomized traffic against a queue-based reference of the capture rules.
module tb_trace_capture;

    logic        clk;
    logic        rst_n;
    logic        arm;
    logic        stop;
    logic        onChange;
    logic [7:0]  sigIn;
    logic        recReady;
    logic        recValid;
    logic [23:0] recData;
    logic        busy;
    logic        done;
    logic        overflow;

    logic        arm4;
    logic        stop4;
    logic        onChange4;
    logic [7:0]  sigIn4;
    logic        recReady4;
    logic        recValid4;
    logic [11:0] recData4;
    logic        busy4;
    logic        done4;
    logic        overflow4;

    int total = 0;
    int bad   = 0;

    trace_capture #(.SIG_W(8), .TS_W(16), .DEPTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .arm(arm), .stop(stop), .on_change(onChange),
        .sig_in(sigIn), .rec_valid(recValid), .rec_ready(recReady),
        .rec_data(recData), .busy(busy), .done(done), .overflow(overflow)
    );

    trace_capture #(.SIG_W(8), .TS_W(4), .DEPTH(4)) dutNarrow (
        .clk(clk), .rst_n(rst_n), .arm(arm4), .stop(stop4), .on_change(onChange4),
        .sig_in(sigIn4), .rec_valid(recValid4), .rec_ready(recReady4),
        .rec_data(recData4), .busy(busy4), .done(done4), .overflow(overflow4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: records are a queue; run mode, cycle index k and timestamp are plain counters.
    logic [23:0] modelQ[$];
    int          modelMode;
    int          modelK;
    int          modelTs;
    logic [7:0]  modelPrev;
    logic        modelDone;
    logic        modelOvf;
    logic [23:0] logQ[$];
    logic [11:0] log4Q[$];

    typedef struct {
        logic        arm;
        logic        stop;
        logic        onChange;
        logic [7:0]  sig;
        logic        ready;
        logic        expValid;
        logic [23:0] expData;
        logic        expBusy;
        logic        expDone;
    } vecT;

    vecT vecs[8];

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        modelQ.delete();
        modelMode = 0;
        modelK    = 0;
        modelTs   = 0;
        modelPrev = 8'h00;
        modelDone = 1'b0;
        modelOvf  = 1'b0;
    endtask

    task automatic modelStep();
        int   sizeBefore;
        logic popNow;
        logic wantPush;
        logic [23:0] rec;
        sizeBefore = modelQ.size();
        popNow     = (sizeBefore > 0) && recReady;
        wantPush   = 1'b0;
        rec        = '0;
        if (modelMode == 0) begin
            if (arm) begin
                modelMode = 1;
                modelK    = 0;
                modelTs   = 0;
                modelDone = 1'b0;
                modelOvf  = 1'b0;
            end
        end else if (modelMode == 1) begin
            wantPush  = (modelK == 0) || !onChange || (sigIn != modelPrev) || (modelTs == 65535);
            rec       = {modelTs[15:0], sigIn};
            modelPrev = sigIn;
            modelTs   = (modelTs + 1) % 65536;
            modelK++;
            if (stop) modelMode = 2;
        end else begin
            if (sizeBefore == 0) begin
                modelMode = 0;
                modelDone = 1'b1;
            end
        end
        if (popNow) void'(modelQ.pop_front());
        if (wantPush) begin
            if (sizeBefore < 16 || popNow) modelQ.push_back(rec);
            else modelOvf = 1'b1;
        end
    endtask

    task automatic checkOutput();
        cmp("rec_valid", 32'(recValid), 32'(modelQ.size() > 0));
        cmp("rec_data", 32'(recData), (modelQ.size() > 0) ? 32'(modelQ[0]) : 32'h0);
        cmp("busy", 32'(busy), 32'(modelMode != 0));
        cmp("done", 32'(done), 32'(modelDone));
        cmp("overflow", 32'(overflow), 32'(modelOvf));
    endtask

    task automatic applyStimulus(input logic a, input logic s, input logic oc,
                                 input logic [7:0] sig, input logic rdy);
        arm      = a;
        stop     = s;
        onChange = oc;
        sigIn    = sig;
        recReady = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        modelStep();
        #1;
        checkOutput();
    endtask

    // Records accepted at the coming edge are logged before the edge.
    task automatic tickLog();
        if (recValid && recReady) logQ.push_back(recData);
        if (recValid4 && recReady4) log4Q.push_back(recData4);
        tick();
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drainLog(input int budget);
        int n = 0;
        while ((busy || recValid) && n < budget) begin
            tickLog();
            n++;
        end
        cmp("drain_timeout", 32'(n < budget), 32'h1);
    endtask

    initial begin
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        arm4 = 1'b0; stop4 = 1'b0; onChange4 = 1'b0; sigIn4 = 8'h00; recReady4 = 1'b0;
        rst_n = 1'b1;
        #2;
        doReset();
        cmp("reset_rec_data", 32'(recData), 32'h0);

        // Change-only run with explicit expected outputs per cycle.
        vecs[0] = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 24'h000000, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 24'h000000, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 24'h000000, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 8'h01, 1'b1, 1'b1, 24'h000201, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 24'h000000, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 8'h03, 1'b1, 1'b1, 24'h000403, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 24'h000000, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 24'h000000, 1'b0, 1'b1};
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].arm, vecs[i].stop, vecs[i].onChange, vecs[i].sig, vecs[i].ready);
            tick();
            cmp("vec_valid", 32'(recValid), 32'(vecs[i].expValid));
            cmp("vec_data", 32'(recData), 32'(vecs[i].expData));
            cmp("vec_busy", 32'(busy), 32'(vecs[i].expBusy));
            cmp("vec_done", 32'(done), 32'(vecs[i].expDone));
        end

        // Every-cycle capture of a held value, stop after 4 cycles.
        doReset();
        logQ.delete();
        applyStimulus(1'b1, 1'b0, 1'b0, 8'hA5, 1'b1);
        tick();
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, k == 4, 1'b0, 8'hA5, 1'b1);
            tickLog();
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 8'hA5, 1'b1);
        drainLog(20);
        cmp("held_count", 32'(logQ.size()), 32'd5);
        for (int i = 0; i < logQ.size() && i < 5; i++) cmp("held_rec", 32'(logQ[i]), {8'h0, i[15:0], 8'hA5});
        cmp("held_done", 32'(done), 32'h1);

        // Overflow: 20 captures with the consumer stalled keep only the first 16.
        doReset();
        logQ.delete();
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h5A, 1'b0);
        tick();
        for (int k = 0; k < 20; k++) begin
            applyStimulus(1'b0, k == 19, 1'b0, 8'(k), 1'b0);
            tick();
        end
        cmp("ovf_set", 32'(overflow), 32'h1);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        drainLog(40);
        cmp("ovf_count", 32'(logQ.size()), 32'd16);
        for (int i = 0; i < logQ.size() && i < 16; i++) cmp("ovf_rec", 32'(logQ[i]), {8'h0, i[15:0], i[7:0]});

        // Full FIFO with a same-cycle pop still accepts the push.
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h11, 1'b0);
        tick();
        for (int k = 0; k < 16; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 8'h11, 1'b0);
            tick();
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h22, 1'b1);
        tick();
        cmp("full_pop_ovf", 32'(overflow), 32'h0);
        cmp("full_pop_head", 32'(recData), 32'h000111);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h22, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h22, 1'b1);
        drainLog(40);

        // Reset while draining five queued records.
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h33, 1'b0);
        tick();
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, k == 4, 1'b0, 8'h33, 1'b0);
            tick();
        end
        tick();
        cmp("predrain_busy", 32'(busy), 32'h1);
        doReset();
        tick();
        cmp("rst_drain_valid", 32'(recValid), 32'h0);
        cmp("rst_drain_busy", 32'(busy), 32'h0);
        cmp("rst_drain_done", 32'(done), 32'h0);
        cmp("rst_drain_ovf", 32'(overflow), 32'h0);

        // Arm and stop together from idle: arm wins.
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h44, 1'b1);
        tick();
        cmp("armstop_busy", 32'(busy), 32'h1);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h44, 1'b1);
        tick();
        cmp("armstop_still_busy", 32'(busy), 32'h1);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h44, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h44, 1'b1);
        drainLog(20);

        // Timestamp wrap on the 4-bit instance: markers at k=0, 15 and 31.
        log4Q.delete();
        arm4 = 1'b1; onChange4 = 1'b1; sigIn4 = 8'h3C; recReady4 = 1'b1;
        tickLog();
        arm4 = 1'b0;
        cmp("wrap_busy", 32'(busy4), 32'h1);
        for (int k = 0; k < 40; k++) begin
            stop4 = (k == 39);
            tickLog();
        end
        stop4 = 1'b0;
        for (int k = 0; k < 6; k++) tickLog();
        cmp("wrap_count", 32'(log4Q.size()), 32'd3);
        if (log4Q.size() == 3) begin
            cmp("wrap_rec0", 32'(log4Q[0]), 32'h03C);
            cmp("wrap_rec1", 32'(log4Q[1]), 32'hF3C);
            cmp("wrap_rec2", 32'(log4Q[2]), 32'hF3C);
        end
        cmp("wrap_done", 32'(done4), 32'h1);
        cmp("wrap_idle", 32'(busy4), 32'h0);

        // Randomized traffic against the reference.
        doReset();
        for (int i = 0; i < 1500; i++) begin
            applyStimulus(($urandom_range(0, 19) == 0), ($urandom_range(0, 24) == 0),
                          (i / 300) % 2 == 1, 8'($urandom_range(0, 3)),
                          ($urandom_range(0, 9) < 6));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
